// File: rtl/program_sequencer.sv
// Program counter with load, PC-relative branch and a hardware call/return stack.
// New PC is registered on each rising edge; bus drive is combinational; no backpressure.
module program_sequencer #(
  parameter int unsigned          AW          = 8,
  parameter int unsigned          STACK_DEPTH = 4,
  parameter logic [AW-1:0]        RESET_ADDR  = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pc_inc,
  input  logic          load_pc,
  input  logic          branch_rel,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] offset,
  input  logic          pc_rd_en,
  output logic [AW-1:0] pc_bus_out,
  output logic [AW-1:0] pc_addr,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          stack_err
);

  // One extra pointer bit so that "full" (sp == STACK_DEPTH) is representable.
  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IW  = SPW - 1;

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [STACK_DEPTH];

  logic           push_en;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;
  logic [AW-1:0]  pc_plus1;
  logic [AW-1:0]  pc_branch;
  logic [SPW-1:0] sp_dec;

  assign pc_plus1  = pc_q + AW'(1);
  assign pc_branch = pc_q + offset;
  assign sp_dec    = sp_q - SPW'(1);
  assign push_idx  = sp_q[IW-1:0];
  assign pop_idx   = sp_dec[IW-1:0];

  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_err   = err_q;

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (load_pc) begin
      pc_d = pc_in;
    end else if (call) begin
      pc_d = pc_in;
      if (!stack_full) begin
        push_en = 1'b1;
        sp_d    = sp_q + SPW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (ret) begin
      if (!stack_empty) begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_dec;
      end else begin
        // Underflow still advances so a stray return does not stall fetch.
        pc_d  = pc_plus1;
        err_d = 1'b1;
      end
    end else if (branch_rel) begin
      pc_d = pc_branch;
    end else if (pc_inc) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_plus1;
    end
  end

  assign pc_addr    = pc_q;
  assign pc_bus_out = pc_rd_en ? pc_q : 'z;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Parametrised program counter for the CPU control path. It extends the plain increment/load PC with three additions:
- PC-relative branch.
- Hardware call/return stack of configurable depth.
- Stack status flags.
It drives the shared data bus through a tri-state output under the control unit's read enable, and presents the current address continuously to instruction memory.

Parameters:
AW, 8, address width in bits (4..16)
STACK_DEPTH, 4, number of return-address entries (power of 2, 2..16)
RESET_ADDR, 0, PC value after reset (AW bits)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
pc_inc  input  1  advance PC by 1 this cycle
load_pc  input  1  absolute jump: PC <= pc_in
branch_rel  input  1  relative jump: PC <= PC + offset
call  input  1  push PC+1, then PC <= pc_in
ret  input  1  pop top of stack into PC
pc_in  input  AW  jump/call target address
offset  input  AW  signed two's-complement branch displacement
pc_rd_en  input  1  drive pc_bus_out onto shared bus
pc_bus_out  output  AW  PC onto bus; high-Z when pc_rd_en=0
pc_addr  output  AW  current PC, always driven (instruction memory address)
stack_empty  output  1  no return addresses held
stack_full  output  1  STACK_DEPTH entries held
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset_n=0, async, immediate):
  - PC=RESET_ADDR, stack pointer=0.
  - stack_empty=1, stack_full=0, stack_err=0.
  - Stack RAM contents are don't-care.
  - Reset asserted mid-operation aborts any pending push/pop; no partial update is kept.
- Single registered state update per rising edge. Control inputs are sampled at the edge; the new PC is visible on pc_addr the same cycle, after the clock-to-Q delay.
- Command priority, highest first (lower-priority commands asserted in the same cycle are ignored):
  1. load_pc: PC <= pc_in. Stack unchanged.
  2. call:
     - Not full: stack[sp] <= PC+1 (mod 2^AW); sp <= sp+1; PC <= pc_in.
     - Full: no push, sp unchanged, PC <= pc_in, stack_err <= 1.
  3. ret:
     - Not empty: PC <= stack[sp-1]; sp <= sp-1.
     - Empty: PC <= PC+1, stack_err <= 1.
  4. branch_rel: PC <= PC + offset, AW-bit modular add (wraps both directions).
  5. pc_inc: PC <= PC+1, wraps 2^AW-1 -> 0.
  6. None asserted: PC holds.
- Arithmetic:
  - All additions are truncated to AW bits; there is no carry-out.
  - offset is sign-interpreted, e.g. AW=8, offset=8'hFE means -2.
- Flags:
  - stack_empty = (sp==0).
  - stack_full = (sp==STACK_DEPTH).
  - Both are combinational from the sp register, so they update the cycle after a push/pop.
- stack_err is sticky until reset. Only call-while-full and ret-while-empty set it.
- Bus output:
  - pc_bus_out = pc_rd_en ? PC : 'z. Purely combinational; adds no latency.
  - pc_addr is unaffected by pc_rd_en.
- sp is a log2(STACK_DEPTH)+1 bit counter. The stack is a register array; no memory read latency.

Test Plan:
- Reset release, AW=8, 5 cycles with pc_inc=1: pc_addr = 00,01,02,03,04,05 (00 during reset, increments on each edge). pc_rd_en=0: pc_bus_out=Z; pc_rd_en=1: pc_bus_out equals pc_addr.
- Wrap and hold: PC=FE, pc_inc 2 cycles -> FF, 00. Then all controls 0 for 3 cycles -> PC stays 00.
- Nested calls and returns:
  - PC=10: call pc_in=40 -> PC=40, stack_empty=0.
  - PC=40: call pc_in=80 -> PC=80.
  - ret -> PC=41; ret -> PC=11; stack_empty=1, stack_err=0.
- Overflow/underflow, STACK_DEPTH=4:
  - 4 calls -> stack_full=1, stack_err=0.
  - 5th call to pc_in=20 -> PC=20, stack_err=1, sp stays 4.
  - 4 rets restore the 4 pushed addresses in LIFO order; stack_empty=1.
  - 5th ret from PC=X -> PC=X+1, stack_err remains 1.
- Relative branch: PC=05, offset=FE -> PC=03. PC=FA, offset=0A -> PC=04 (wrap).
- Priority and async reset:
  - load_pc + call + pc_inc same cycle, pc_in=33 -> PC=33, stack unchanged.
  - ret + branch_rel -> ret wins.
  - reset_n pulsed low between edges during a call sequence -> PC=RESET_ADDR and stack_empty=1 immediately, without waiting for a clock edge.
